cdb_arbiter: RTL and testbench

Round-robin arbiter and buffer in front of the common data bus (CDB). The ALU, branch ALU and load/store unit each push completed results (ROB tag plus value) into a private 2-entry queue. Each cycle the arbiter picks one non-empty queue and drives a single registered broadcast (valid, tag, data, source) that feeds the reservation stations, ROB and PC. Units therefore never collide on the bus, and a stalled unit is back-pressured through its ready line instead of losing a result.

---
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit 2-deep result queues with a round-robin pick that
// drives one registered common-data-bus broadcast per cycle.
module cdb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int TAG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter logic [TAG_WIDTH-1:0] NO_TAG = '1,
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          cdb_valid,
    output logic [TAG_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [SRC_W-1:0]              cdb_src
);

    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_REQ][2];
    logic [DATA_WIDTH-1:0] data_mem [NUM_REQ][2];
    logic [1:0]            count    [NUM_REQ];
    logic [NUM_REQ-1:0]    wr_ptr;
    logic [NUM_REQ-1:0]    rd_ptr;
    logic [SRC_W-1:0]      last_grant;

    logic [NUM_REQ-1:0]    push;
    logic [NUM_REQ-1:0]    pop;
    logic                  grant_found;
    logic [SRC_W-1:0]      grant_idx;

    // k-th candidate index after the last winner, wrapping around
    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int k);
        int v;
        v = (int'(base) + 1 + k) % NUM_REQ;
        return SRC_W'(v);
    endfunction

    // ready depends only on registered counts; a full queue never bypasses
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (count[i] != 2'd2);
        end
    end

    // round-robin search over queues that held data before this edge
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && count[rr_idx(last_grant, k)] != 2'd0) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx(last_grant, k);
            end
        end
    end

    // accepted pushes and the winner's pop; flush suppresses both
    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i] = req_valid[i] && req_ready[i] && !flush;
            pop[i]  = grant_found && (int'(grant_idx) == i) && !flush;
        end
    end

    // queue storage; contents are only meaningful under a nonzero count
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]  <= req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                data_mem[i][wr_ptr[i]] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // queue bookkeeping, grant history and the broadcast register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i] <= 2'd0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= SRC_W'(NUM_REQ - 1);
            cdb_valid  <= 1'b0;
            cdb_tag    <= NO_TAG;
            cdb_data   <= '0;
            cdb_src    <= '0;
        end else if (flush) begin
            // last_grant deliberately survives a flush
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i] <= 2'd0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= NO_TAG;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
                if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
                count[i] <= count[i] + 2'(push[i]) - 2'(pop[i]);
            end
            if (grant_found) begin
                last_grant <= grant_idx;
                cdb_valid  <= 1'b1;
                cdb_tag    <= tag_mem[grant_idx][rd_ptr[grant_idx]];
                cdb_data   <= data_mem[grant_idx][rd_ptr[grant_idx]];
                cdb_src    <= grant_idx;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= NO_TAG;
                cdb_data  <= '0;
                cdb_src   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, rotation, back-pressure, flush, async reset.
module tb_cdb_arbiter;

    localparam int NR = 3;
    localparam int TW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [NR-1:0]   req_valid;
    logic [NR*TW-1:0] req_tag;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      cdb_src;

    int n_checks = 0;
    int n_errors = 0;
    logic [NR-1:0] rdy_log [0:8];

    cdb_arbiter #(.NUM_REQ(NR), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] mk_tag(input int i, input int c);
        return TW'(i * 8 + c);
    endfunction

    function automatic logic [DW-1:0] mk_data(input int i, input int c);
        return DW'(32'h1000_0000 * (i + 1) + 32'h0000_0100 + c);
    endfunction

    task automatic check_idle(input string name);
        check({name, "_valid"}, 64'(cdb_valid), 64'd0);
        check({name, "_tag"},   64'(cdb_tag),   64'd31);
        check({name, "_data"},  64'(cdb_data),  64'd0);
        check({name, "_src"},   64'(cdb_src),   64'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_tag[i*TW +: TW]  = t;
        req_data[i*DW +: DW] = d;
    endtask

    // each requester holds its current item until ready accepts it
    task automatic run_stream(input int n0, input int n1, input int n2, input int rr_limit);
        int n [NR];
        int ptr [NR];
        int exp_cnt [NR];
        logic acc [NR];
        int k;
        int cyc;
        int s;
        n = '{n0, n1, n2};
        ptr = '{0, 0, 0};
        exp_cnt = '{0, 0, 0};
        k = 0;
        cyc = 0;
        while (k < n0 + n1 + n2 && cyc < 100) begin
            for (int i = 0; i < NR; i++) begin
                if (ptr[i] < n[i]) set_req(i, 1'b1, mk_tag(i, ptr[i]), mk_data(i, ptr[i]));
                else               set_req(i, 1'b0, '0, '0);
                acc[i] = req_valid[i] && req_ready[i];
            end
            tick();
            cyc++;
            if (cyc <= 8) rdy_log[cyc] = req_ready;
            for (int i = 0; i < NR; i++) if (acc[i]) ptr[i]++;
            if (cdb_valid) begin
                s = int'(cdb_src);
                if (k < rr_limit) check("rr_src", 64'(cdb_src), 64'(k % 3));
                if (s < NR) begin
                    check("stream_tag",  64'(cdb_tag),  64'(mk_tag(s, exp_cnt[s])));
                    check("stream_data", 64'(cdb_data), 64'(mk_data(s, exp_cnt[s])));
                    exp_cnt[s]++;
                end else begin
                    check("stream_src_range", 64'(cdb_src), 64'd0);
                end
                k++;
            end
        end
        req_valid = '0;
        check("stream_count", 64'(k), 64'(n0 + n1 + n2));
        check("stream_n0", 64'(exp_cnt[0]), 64'(n0));
        check("stream_n1", 64'(exp_cnt[1]), 64'(n1));
        check("stream_n2", 64'(exp_cnt[2]), 64'(n2));
        tick();
        check("stream_tail_idle", 64'(cdb_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_tag = '0;
        req_data = '0;

        // reset idle
        #1;
        check_idle("rst_held");
        tick();
        rst = 1'b0;
        tick();
        check_idle("rst_rel");
        check("rst_ready", 64'(req_ready), 64'h7);

        // single push: visible only after the second edge
        set_req(0, 1'b1, 5'd5, 32'h1234_5678);
        tick();
        req_valid = '0;
        check("single_t0_valid", 64'(cdb_valid), 64'd0);
        tick();
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_tag",   64'(cdb_tag),   64'd5);
        check("single_data",  64'(cdb_data),  64'h1234_5678);
        check("single_src",   64'(cdb_src),   64'd0);
        tick();
        check_idle("single_after");

        // round robin with all three contending
        do_reset();
        run_stream(6, 6, 6, 18);

        // back-pressure on the LSM queue
        do_reset();
        run_stream(6, 6, 4, 12);
        check("bp_rdy2_e1", 64'(rdy_log[1][2]), 64'd1);
        check("bp_rdy2_e2", 64'(rdy_log[2][2]), 64'd0);
        check("bp_rdy2_e3", 64'(rdy_log[3][2]), 64'd0);
        check("bp_rdy2_e4", 64'(rdy_log[4][2]), 64'd1);
        check("bp_rdy2_e5", 64'(rdy_log[5][2]), 64'd0);

        // flush discards queued and same-cycle results, keeps last_grant
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, TW'(10 + i), DW'(32'hF00 + i));
        tick();
        req_valid = '0;
        tick();
        check("fl_pre_tag", 64'(cdb_tag), 64'd10);
        check("fl_pre_src", 64'(cdb_src), 64'd0);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, TW'(20 + i), DW'(32'hE00 + i));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = '0;
        check_idle("fl_next");
        check("fl_ready", 64'(req_ready), 64'h7);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("fl_stays_idle", 64'(cdb_valid), 64'd0);
        end
        set_req(0, 1'b1, 5'd1, 32'hA1);
        set_req(1, 1'b1, 5'd2, 32'hA2);
        tick();
        req_valid = '0;
        tick();
        check("fl_lg_src1", 64'(cdb_src), 64'd1);
        check("fl_lg_tag1", 64'(cdb_tag), 64'd2);
        tick();
        check("fl_lg_src0", 64'(cdb_src), 64'd0);
        check("fl_lg_tag0", 64'(cdb_tag), 64'd1);
        tick();
        check("fl_lg_idle", 64'(cdb_valid), 64'd0);

        // async reset between edges
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, TW'(24 + i), DW'(32'hD00 + i));
        tick();
        tick();
        tick();
        check("ar_busy", 64'(cdb_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        check_idle("ar_async");
        check("ar_ready", 64'(req_ready), 64'h7);
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("ar_no_stale", 64'(cdb_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
